// File: rtl/axi_xbar_if.sv
// AXI-lite bus bundle used on every port of axi_xbar.
//   master modport : drives address/data/valid requests, rready, bready
//   slave modport  : drives readys, read data and write response
// Channels: ar (araddr/arvalid/arready), r (rdata/rresp/rvalid/rready),
//           aw (awaddr/awvalid/awready), w (wdata/wstrb/wvalid/wready),
//           b (bresp/bvalid/bready).
interface axi_xbar_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [7:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output araddr, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready,
      output awaddr, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready
   );

   modport slave (
      input  araddr, arvalid, output arready,
      output rdata, rresp, rvalid, input rready,
      input  awaddr, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready
   );
endinterface

// File: rtl/axi_xbar.sv
// Single-master, three-slave AXI-lite address router (s0 SRAM, s1 UART, s2 CLINT).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   m    - upstream port from the memory arbiter (slave modport)
//   s0..s2 - downstream ports to the devices (master modports)
// Read and write paths are independent FSMs, one outstanding transaction each.
// Optional macro XBAR_DECERR_EN: unmapped addresses get a DECERR (2'b11) response
// without touching any slave; when undefined they route to s0.
module axi_xbar #(
   parameter logic [31:0] S0_BASE = 32'h8000_0000,
   parameter logic [31:0] S0_MASK = 32'hf800_0000,
   parameter logic [31:0] S1_BASE = 32'ha000_03f8,
   parameter logic [31:0] S1_MASK = 32'hffff_fff8,
   parameter logic [31:0] S2_BASE = 32'ha000_0048,
   parameter logic [31:0] S2_MASK = 32'hffff_fff0
) (
   input logic        clk,
   input logic        rst,
   axi_xbar_if.slave  m,
   axi_xbar_if.master s0,
   axi_xbar_if.master s1,
   axi_xbar_if.master s2
);

   // Slave index, priority s1 > s2 > s0; unmapped falls back to s0.
   function automatic logic [1:0] decode_sel(input logic [31:0] a);
      if ((a & S1_MASK) == (S1_BASE & S1_MASK)) return 2'd1;
      if ((a & S2_MASK) == (S2_BASE & S2_MASK)) return 2'd2;
      return 2'd0;
   endfunction

   logic r_map, w_map;
`ifdef XBAR_DECERR_EN
   function automatic logic is_mapped(input logic [31:0] a);
      return ((a & S0_MASK) == (S0_BASE & S0_MASK)) ||
             ((a & S1_MASK) == (S1_BASE & S1_MASK)) ||
             ((a & S2_MASK) == (S2_BASE & S2_MASK));
   endfunction
   assign r_map = is_mapped(m.araddr);
   assign w_map = is_mapped(m.awaddr);
`else
   assign r_map = 1'b1;
   assign w_map = 1'b1;
`endif

   // ---------------- read path ----------------
   typedef enum logic [1:0] {RIdle, RAddr, RData, RErr} r_state_e;
   r_state_e    r_state_q, r_state_d;
   logic [31:0] raddr_q;
   logic [1:0]  rsel_q;
   logic        r_acc;
   logic        sel_arready, sel_rvalid;
   logic [31:0] sel_rdata;
   logic [1:0]  sel_rresp;

   assign r_acc = (r_state_q == RIdle) && m.arvalid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state_q <= RIdle;
         raddr_q   <= '0;
         rsel_q    <= '0;
      end else begin
         r_state_q <= r_state_d;
         // Unmapped requests are not latched so no slave port toggles.
         if (r_acc && r_map) begin
            raddr_q <= m.araddr;
            rsel_q  <= decode_sel(m.araddr);
         end
      end
   end

   always_comb begin
      unique case (rsel_q)
         2'd1:    begin sel_arready = s1.arready; sel_rvalid = s1.rvalid;
                        sel_rdata = s1.rdata; sel_rresp = s1.rresp; end
         2'd2:    begin sel_arready = s2.arready; sel_rvalid = s2.rvalid;
                        sel_rdata = s2.rdata; sel_rresp = s2.rresp; end
         default: begin sel_arready = s0.arready; sel_rvalid = s0.rvalid;
                        sel_rdata = s0.rdata; sel_rresp = s0.rresp; end
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      unique case (r_state_q)
         RIdle: if (r_acc) begin
`ifdef XBAR_DECERR_EN
            r_state_d = r_map ? RAddr : RErr;
`else
            r_state_d = RAddr;
`endif
         end
         RAddr: if (sel_arready) r_state_d = RData;
         RData: if (sel_rvalid && m.rready) r_state_d = RIdle;
`ifdef XBAR_DECERR_EN
         RErr:  if (m.rready) r_state_d = RIdle;
`endif
         default: r_state_d = RIdle;
      endcase
   end

   always_comb begin
      m.arready  = 1'b0;
      m.rvalid   = 1'b0;
      m.rdata    = '0;
      m.rresp    = '0;
      s0.arvalid = 1'b0;
      s1.arvalid = 1'b0;
      s2.arvalid = 1'b0;
      s0.rready  = 1'b0;
      s1.rready  = 1'b0;
      s2.rready  = 1'b0;
      unique case (r_state_q)
         RIdle: m.arready = rst;  // held low while reset is asserted
         RAddr: begin
            unique case (rsel_q)
               2'd1:    s1.arvalid = 1'b1;
               2'd2:    s2.arvalid = 1'b1;
               default: s0.arvalid = 1'b1;
            endcase
         end
         RData: begin
            m.rvalid = sel_rvalid;
            m.rdata  = sel_rdata;
            m.rresp  = sel_rresp;
            unique case (rsel_q)
               2'd1:    s1.rready = m.rready;
               2'd2:    s2.rready = m.rready;
               default: s0.rready = m.rready;
            endcase
         end
`ifdef XBAR_DECERR_EN
         RErr: begin
            m.rvalid = 1'b1;
            m.rresp  = 2'b11;
         end
`endif
         default: ;
      endcase
   end

   assign s0.araddr = raddr_q;
   assign s1.araddr = raddr_q;
   assign s2.araddr = raddr_q;

   // ---------------- write path ----------------
   typedef enum logic [1:0] {WIdle, WReq, WResp, WErr} w_state_e;
   w_state_e    w_state_q, w_state_d;
   logic [31:0] waddr_q, wdata_q;
   logic [7:0]  wstrb_q;
   logic [1:0]  wsel_q;
   logic        aw_pend_q, w_pend_q;  // set on accept, cleared by each downstream handshake
   logic        w_acc;
   logic        sel_awready, sel_wready, sel_bvalid;
   logic [1:0]  sel_bresp;

   assign w_acc = (w_state_q == WIdle) && m.awvalid && m.wvalid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_state_q <= WIdle;
         waddr_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         wsel_q    <= '0;
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         if (w_acc && w_map) begin
            waddr_q   <= m.awaddr;
            wdata_q   <= m.wdata;
            wstrb_q   <= m.wstrb;
            wsel_q    <= decode_sel(m.awaddr);
            aw_pend_q <= 1'b1;
            w_pend_q  <= 1'b1;
         end else if (w_state_q == WReq) begin
            if (sel_awready) aw_pend_q <= 1'b0;
            if (sel_wready)  w_pend_q  <= 1'b0;
         end
      end
   end

   always_comb begin
      unique case (wsel_q)
         2'd1:    begin sel_awready = s1.awready; sel_wready = s1.wready;
                        sel_bvalid = s1.bvalid; sel_bresp = s1.bresp; end
         2'd2:    begin sel_awready = s2.awready; sel_wready = s2.wready;
                        sel_bvalid = s2.bvalid; sel_bresp = s2.bresp; end
         default: begin sel_awready = s0.awready; sel_wready = s0.wready;
                        sel_bvalid = s0.bvalid; sel_bresp = s0.bresp; end
      endcase
   end

   always_comb begin
      w_state_d = w_state_q;
      unique case (w_state_q)
         WIdle: if (w_acc) begin
`ifdef XBAR_DECERR_EN
            w_state_d = w_map ? WReq : WErr;
`else
            w_state_d = WReq;
`endif
         end
         WReq: if ((!aw_pend_q || sel_awready) && (!w_pend_q || sel_wready)) w_state_d = WResp;
         WResp: if (sel_bvalid && m.bready) w_state_d = WIdle;
`ifdef XBAR_DECERR_EN
         WErr: if (m.bready) w_state_d = WIdle;
`endif
         default: w_state_d = WIdle;
      endcase
   end

   always_comb begin
      m.awready  = 1'b0;
      m.wready   = 1'b0;
      m.bvalid   = 1'b0;
      m.bresp    = '0;
      s0.awvalid = 1'b0;
      s1.awvalid = 1'b0;
      s2.awvalid = 1'b0;
      s0.wvalid  = 1'b0;
      s1.wvalid  = 1'b0;
      s2.wvalid  = 1'b0;
      s0.bready  = 1'b0;
      s1.bready  = 1'b0;
      s2.bready  = 1'b0;
      unique case (w_state_q)
         WIdle: begin
            m.awready = rst && m.awvalid && m.wvalid;
            m.wready  = rst && m.awvalid && m.wvalid;
         end
         WReq: begin
            unique case (wsel_q)
               2'd1:    begin s1.awvalid = aw_pend_q; s1.wvalid = w_pend_q; end
               2'd2:    begin s2.awvalid = aw_pend_q; s2.wvalid = w_pend_q; end
               default: begin s0.awvalid = aw_pend_q; s0.wvalid = w_pend_q; end
            endcase
         end
         WResp: begin
            m.bvalid = sel_bvalid;
            m.bresp  = sel_bresp;
            unique case (wsel_q)
               2'd1:    s1.bready = m.bready;
               2'd2:    s2.bready = m.bready;
               default: s0.bready = m.bready;
            endcase
         end
`ifdef XBAR_DECERR_EN
         WErr: begin
            m.bvalid = 1'b1;
            m.bresp  = 2'b11;
         end
`endif
         default: ;
      endcase
   end

   assign s0.awaddr = waddr_q;
   assign s1.awaddr = waddr_q;
   assign s2.awaddr = waddr_q;
   assign s0.wdata  = wdata_q;
   assign s1.wdata  = wdata_q;
   assign s2.wdata  = wdata_q;
   assign s0.wstrb  = wstrb_q;
   assign s1.wstrb  = wstrb_q;
   assign s2.wstrb  = wstrb_q;

endmodule

// File: tb/tb_axi_xbar.sv
// Directed self-checking bench for axi_xbar; honours XBAR_DECERR_EN if defined.
module tb_axi_xbar;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   axi_xbar_if m_bus ();
   axi_xbar_if s0_bus ();
   axi_xbar_if s1_bus ();
   axi_xbar_if s2_bus ();

   axi_xbar dut (
      .clk (clk),
      .rst (rst),
      .m   (m_bus),
      .s0  (s0_bus),
      .s1  (s1_bus),
      .s2  (s2_bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 2-3 time units after the rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      m_bus.araddr = '0; m_bus.arvalid = 0; m_bus.rready = 0;
      m_bus.awaddr = '0; m_bus.awvalid = 0; m_bus.wdata = '0;
      m_bus.wstrb = '0; m_bus.wvalid = 0; m_bus.bready = 0;
      s0_bus.arready = 0; s0_bus.rdata = '0; s0_bus.rresp = '0; s0_bus.rvalid = 0;
      s0_bus.awready = 0; s0_bus.wready = 0; s0_bus.bresp = '0; s0_bus.bvalid = 0;
      s1_bus.arready = 0; s1_bus.rdata = '0; s1_bus.rresp = '0; s1_bus.rvalid = 0;
      s1_bus.awready = 0; s1_bus.wready = 0; s1_bus.bresp = '0; s1_bus.bvalid = 0;
      s2_bus.arready = 0; s2_bus.rdata = '0; s2_bus.rresp = '0; s2_bus.rvalid = 0;
      s2_bus.awready = 0; s2_bus.wready = 0; s2_bus.bresp = '0; s2_bus.bvalid = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      // Reset state
      #3;
      check("rst_arready", m_bus.arready, 0);
      check("rst_rvalid", m_bus.rvalid, 0);
      check("rst_bvalid", m_bus.bvalid, 0);
      check("rst_rdata", m_bus.rdata, 0);
      check("rst_s0_arvalid", s0_bus.arvalid, 0);
      check("rst_s0_araddr", s0_bus.araddr, 0);
      check("rst_s1_awvalid", s1_bus.awvalid, 0);
      step();
      rst = 1'b1;
      step();

      // SRAM read, data returned 3 cycles after the address handshake
      m_bus.araddr = 32'h8000_0010; m_bus.arvalid = 1;
      settle();
      check("rd_arready", m_bus.arready, 1);
      step();
      m_bus.arvalid = 0;
      settle();
      check("rd_s0_arvalid", s0_bus.arvalid, 1);
      check("rd_s0_araddr", s0_bus.araddr, 32'h8000_0010);
      check("rd_s1_idle", {s1_bus.arvalid, s1_bus.rready}, 0);
      check("rd_s2_idle", {s2_bus.arvalid, s2_bus.rready}, 0);
      s0_bus.arready = 1;
      step();
      s0_bus.arready = 0;
      settle();
      check("rd_s0_arvalid_drop", s0_bus.arvalid, 0);
      step();
      step();
      s0_bus.rvalid = 1; s0_bus.rdata = 32'hdead_beef; s0_bus.rresp = 2'b00;
      m_bus.rready = 1;
      settle();
      check("rd_rvalid", m_bus.rvalid, 1);
      check("rd_rdata", m_bus.rdata, 32'hdead_beef);
      check("rd_rresp", m_bus.rresp, 0);
      check("rd_s0_rready", s0_bus.rready, 1);
      step();
      s0_bus.rvalid = 0; m_bus.rready = 0;
      settle();
      check("rd_done_rvalid", m_bus.rvalid, 0);
      check("rd_done_arready", m_bus.arready, 1);

      // UART write, awready two cycles after wready
      m_bus.awaddr = 32'ha000_03f8; m_bus.wdata = 32'h41; m_bus.wstrb = 8'h01;
      m_bus.awvalid = 1; m_bus.wvalid = 1;
      settle();
      check("wr_awready", m_bus.awready, 1);
      check("wr_wready", m_bus.wready, 1);
      step();
      m_bus.awvalid = 0; m_bus.wvalid = 0;
      settle();
      check("wr_s1_valids", {s1_bus.awvalid, s1_bus.wvalid}, 2'b11);
      check("wr_s1_awaddr", s1_bus.awaddr, 32'ha000_03f8);
      check("wr_s1_wdata", s1_bus.wdata, 32'h41);
      check("wr_s1_wstrb", s1_bus.wstrb, 8'h01);
      check("wr_s0_idle", {s0_bus.awvalid, s0_bus.wvalid}, 0);
      s1_bus.wready = 1;
      step();
      s1_bus.wready = 0;
      settle();
      check("wr_s1_after_w", {s1_bus.awvalid, s1_bus.wvalid}, 2'b10);
      step();
      s1_bus.awready = 1;
      step();
      s1_bus.awready = 0;
      settle();
      check("wr_s1_awvalid_drop", s1_bus.awvalid, 0);
      check("wr_no_early_bvalid", m_bus.bvalid, 0);
      step();
      s1_bus.bvalid = 1; s1_bus.bresp = 2'b00; m_bus.bready = 1;
      settle();
      check("wr_bvalid", m_bus.bvalid, 1);
      check("wr_bresp", m_bus.bresp, 0);
      check("wr_s1_bready", s1_bus.bready, 1);
      step();
      s1_bus.bvalid = 0; m_bus.bready = 0;
      settle();
      check("wr_done_bvalid", m_bus.bvalid, 0);

      // Unmapped read
      m_bus.araddr = 32'h0000_1000; m_bus.arvalid = 1;
      step();
      m_bus.arvalid = 0;
      settle();
`ifdef XBAR_DECERR_EN
      check("dec_rvalid", m_bus.rvalid, 1);
      check("dec_rresp", m_bus.rresp, 2'b11);
      check("dec_rdata", m_bus.rdata, 0);
      check("dec_no_arvalid", {s0_bus.arvalid, s1_bus.arvalid, s2_bus.arvalid}, 0);
      m_bus.rready = 1;
      step();
      m_bus.rready = 0;
      settle();
      check("dec_done_rvalid", m_bus.rvalid, 0);
`else
      check("def_s0_arvalid", s0_bus.arvalid, 1);
      check("def_s0_araddr", s0_bus.araddr, 32'h0000_1000);
      s0_bus.arready = 1;
      step();
      s0_bus.arready = 0;
      // Slave error response must pass through untouched.
      s0_bus.rvalid = 1; s0_bus.rresp = 2'b10; s0_bus.rdata = 32'h0bad_0bad; m_bus.rready = 1;
      settle();
      check("def_rresp", m_bus.rresp, 2'b10);
      check("def_rdata", m_bus.rdata, 32'h0bad_0bad);
      step();
      s0_bus.rvalid = 0; s0_bus.rresp = 0; m_bus.rready = 0;
`endif

      // Concurrent CLINT read and SRAM write
      m_bus.araddr = 32'ha000_0048; m_bus.arvalid = 1;
      m_bus.awaddr = 32'h8000_0000; m_bus.wdata = 32'h1234_5678; m_bus.wstrb = 8'hff;
      m_bus.awvalid = 1; m_bus.wvalid = 1;
      settle();
      check("cc_accept", {m_bus.arready, m_bus.awready, m_bus.wready}, 3'b111);
      step();
      m_bus.arvalid = 0; m_bus.awvalid = 0; m_bus.wvalid = 0;
      settle();
      check("cc_s2_arvalid", s2_bus.arvalid, 1);
      check("cc_s2_araddr", s2_bus.araddr, 32'ha000_0048);
      check("cc_s0_wr_valids", {s0_bus.awvalid, s0_bus.wvalid}, 2'b11);
      check("cc_s0_wdata", s0_bus.wdata, 32'h1234_5678);
      check("cc_cross_idle", {s0_bus.arvalid, s2_bus.awvalid, s2_bus.wvalid}, 0);
      s2_bus.arready = 1; s0_bus.awready = 1; s0_bus.wready = 1;
      step();
      s2_bus.arready = 0; s0_bus.awready = 0; s0_bus.wready = 0;
      s0_bus.bvalid = 1; s0_bus.bresp = 2'b00; m_bus.bready = 1;
      settle();
      check("cc_bvalid", m_bus.bvalid, 1);
      check("cc_rvalid_not_yet", m_bus.rvalid, 0);
      step();
      s0_bus.bvalid = 0; m_bus.bready = 0;
      s2_bus.rvalid = 1; s2_bus.rdata = 32'hcafe_0001; m_bus.rready = 1;
      settle();
      check("cc_rvalid", m_bus.rvalid, 1);
      check("cc_rdata", m_bus.rdata, 32'hcafe_0001);
      check("cc_bvalid_done", m_bus.bvalid, 0);
      step();
      s2_bus.rvalid = 0; m_bus.rready = 0;

      // Reset asserted while in R_DATA with rready low
      m_bus.araddr = 32'h8000_0004; m_bus.arvalid = 1;
      step();
      m_bus.arvalid = 0;
      s0_bus.arready = 1;
      step();
      s0_bus.arready = 0;
      s0_bus.rvalid = 1; s0_bus.rdata = 32'h5555_aaaa;
      settle();
      check("mr_rvalid_before", m_bus.rvalid, 1);
      rst = 1'b0;
      settle();
      check("mr_rvalid_drop", m_bus.rvalid, 0);
      check("mr_arready_low", m_bus.arready, 0);
      check("mr_s0_araddr", s0_bus.araddr, 0);
      s0_bus.rvalid = 0;
      step();
      rst = 1'b1;
      step();
      m_bus.araddr = 32'h8000_0000; m_bus.arvalid = 1;
      step();
      m_bus.arvalid = 0;
      settle();
      check("mr_fresh_arvalid", s0_bus.arvalid, 1);
      check("mr_fresh_araddr", s0_bus.araddr, 32'h8000_0000);
      s0_bus.arready = 1;
      step();
      s0_bus.arready = 0;
      s0_bus.rvalid = 1; s0_bus.rdata = 32'h0000_0077; m_bus.rready = 1;
      settle();
      check("mr_fresh_rdata", m_bus.rdata, 32'h0000_0077);
      step();
      s0_bus.rvalid = 0; m_bus.rready = 0;
      settle();
      check("mr_fresh_done", m_bus.rvalid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/axi_xbar.md
# axi_xbar

- Single-master, three-slave AXI-lite address router.
- Sits between the memory arbiter and the memory-mapped devices, i.e. directly downstream of the arbiter's memory port.
- Decodes each read and write address, forwards the transaction to SRAM, UART or CLINT, and returns the selected slave's response to the arbiter.
- Tracks one outstanding transaction per channel and can generate decode errors for unmapped addresses.

## Interface
Parameters:
- S0_BASE, 32'h8000_0000, SRAM region base
- S0_MASK, 32'hf800_0000, SRAM region mask (128 MiB)
- S1_BASE, 32'ha000_03f8, UART region base
- S1_MASK, 32'hffff_fff8, UART region mask
- S2_BASE, 32'ha000_0048, CLINT region base
- S2_MASK, 32'hffff_fff0, CLINT region mask

Ports:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- m_araddr/m_arvalid/m_arready  in/in/out  32/1/1  upstream read address
- m_rdata/m_rresp/m_rvalid/m_rready  out/out/out/in  32/2/1/1  upstream read data
- m_awaddr/m_awvalid/m_awready  in/in/out  32/1/1  upstream write address
- m_wdata/m_wstrb/m_wvalid/m_wready  in/in/in/out  32/8/1/1  upstream write data
- m_bresp/m_bvalid/m_bready  out/out/in  2/1/1  upstream write response
- sN_* for N = 0,1,2  mirror set  same widths, opposite directions  one full AXI-lite master port per slave (s0 SRAM, s1 UART, s2 CLINT)

## Operation
- Decode: region N hits when (addr & SN_MASK) == (SN_BASE & SN_MASK).
  - Priority when more than one region hits: s1 > s2 > s0.
  - No hit is "unmapped"; see Configuration.
- Read FSM states: R_IDLE, R_ADDR, R_DATA, R_ERR.
  - R_IDLE: m_arready=1. When m_arvalid is high, latch araddr and the select, then go to R_ADDR, or to R_ERR if unmapped.
  - R_ADDR: drive sN_arvalid=1 with the latched address. On sN_arready, go to R_DATA.
  - R_DATA: sN_rvalid/rdata/rresp pass combinationally to m_*, and m_rready passes to sN_rready. On handshake, go to R_IDLE.
  - R_ERR: m_rvalid=1, m_rresp=2'b11, m_rdata=0. On m_rready, go to R_IDLE.
- Write FSM states: W_IDLE, W_REQ, W_RESP, W_ERR.
  - W_IDLE: m_awready = m_wready = (m_awvalid & m_wvalid). Both channels are accepted in the same cycle; latch awaddr, wdata, wstrb and the select.
  - W_REQ: assert sN_awvalid and sN_wvalid independently. Flags aw_done and w_done clear as each handshake occurs. When both are done, go to W_RESP; both handshakes completing in the same cycle is legal.
  - W_RESP: sN_bvalid/bresp pass through, and m_bready passes to sN_bready. On handshake, go to W_IDLE.
  - W_ERR: m_bvalid=1, m_bresp=2'b11. On m_bready, go to W_IDLE.
- Read and write FSMs run independently and may target the same slave concurrently.
- Slave error responses (rresp/bresp ≠ 0) pass through unmodified.
- Non-selected slave ports hold all valid/ready outputs at 0.

## Timing
- Reset values:
  - All m_* ready/valid outputs = 0; m_rdata = 0; m_rresp = m_bresp = 0.
  - All sN_* valid/ready = 0; sN addr/data/strb = 0.
  - FSMs in R_IDLE/W_IDLE.
- Reset asserted mid-transaction: the FSMs return to idle immediately and asynchronously. The in-flight transaction is dropped with no response.
- Read latency added by the xbar: +1 cycle on the address path (accept in cycle T, sN_arvalid in T+1). The data path is combinational, 0 cycles.
- Write latency added: +1 cycle on address/data; the response path is 0 cycles.
- Decode-error response: m_rvalid/m_bvalid rise the cycle after acceptance.
- A new request is accepted at the earliest in the cycle after the previous response handshake, because the FSM must be back in idle.
- sN_*valid stays high until its handshake; the xbar never withdraws a request.

## Configuration
- Macro XBAR_DECERR_EN.
  - Defined: unmapped addresses take R_ERR/W_ERR. No slave port toggles, and the response is 2'b11 (DECERR).
  - Undefined: unmapped addresses route to s0 (SRAM default slave). R_ERR/W_ERR are not built.

## Test plan
- Read 0x8000_0010, SRAM returns rdata=0xdeadbeef after 3 cycles:
  - s0_arvalid rises in the cycle after m_arvalid is accepted;
  - m_rdata=0xdeadbeef, m_rresp=0;
  - s1 and s2 stay idle.
- Write 0xa000_03f8 with wdata=0x41, wstrb=0x01, and UART asserts awready 2 cycles after wready:
  - s1 receives both handshakes;
  - m_bvalid rises only after s1_bvalid;
  - bresp=0.
- Read 0x0000_1000 with XBAR_DECERR_EN defined:
  - m_rvalid in cycle T+1, m_rresp=2'b11, m_rdata=0;
  - no sN_arvalid asserted.
- Same stimulus without XBAR_DECERR_EN:
  - s0_arvalid asserted with address 0x0000_1000.
- Concurrent read of 0xa000_0048 (CLINT) and write of 0x8000_0000 (SRAM) in the same cycle:
  - both accepted;
  - both complete independently;
  - responses correct on each channel.
- rst driven to 0 while in R_DATA with m_rready held low:
  - all valids drop in the same cycle;
  - after release, a fresh read of 0x8000_0000 completes normally.
